// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared width, op encodings, FSM states and a conditional-negate helper
package hilo_muldiv_pkg;
  localparam int DATA_BUS = 32;
  typedef enum logic [2:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
  } hilo_op_e;
  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_e;
  function automatic logic [DATA_BUS-1:0] cond_neg(input logic [DATA_BUS-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: EX-side request and HI/LO write-back bundle for hilo_muldiv
interface hilo_muldiv_if
  import hilo_muldiv_pkg::*;
();
  logic                start;
  logic [2:0]          op;
  logic [DATA_BUS-1:0] operand_a;
  logic [DATA_BUS-1:0] operand_b;
  logic [DATA_BUS-1:0] hi_input_data;
  logic [DATA_BUS-1:0] lo_input_data;
  logic                flush;
  logic                busy;
  logic                hilo_write_en;
  logic [DATA_BUS-1:0] hi_write_data;
  logic [DATA_BUS-1:0] lo_write_data;
  modport master (
    output start, op, operand_a, operand_b, hi_input_data, lo_input_data, flush,
    input  busy, hilo_write_en, hi_write_data, lo_write_data
  );
  modport slave (
    input  start, op, operand_a, operand_b, hi_input_data, lo_input_data, flush,
    output busy, hilo_write_en, hi_write_data, lo_write_data
  );
endinterface

// File: rtl/hilo_muldiv_div_core.sv
// div_core: 32-iteration restoring divider on magnitudes; outputs are the post-iteration values
module div_core
  import hilo_muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                run,
  input  logic [DATA_BUS-1:0] dividend,
  input  logic [DATA_BUS-1:0] divisor,
  output logic [DATA_BUS-1:0] quot_nxt,
  output logic [DATA_BUS-1:0] rem_nxt,
  output logic                last
);
  logic [DATA_BUS-1:0] rem_q, quot_q, dvs_q;
  logic [5:0]          cnt;
  logic [DATA_BUS:0]   shifted, diff;
  assign shifted  = {rem_q, quot_q[DATA_BUS-1]};
  // partial remainder stays below the divisor, so bit DATA_BUS of diff is the borrow
  assign diff     = shifted - {1'b0, dvs_q};
  assign quot_nxt = {quot_q[DATA_BUS-2:0], ~diff[DATA_BUS]};
  assign rem_nxt  = diff[DATA_BUS] ? shifted[DATA_BUS-1:0] : diff[DATA_BUS-1:0];
  assign last     = cnt == 6'd31;
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt    <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvs_q  <= divisor;
      cnt    <= '0;
    end else if (run) begin
      rem_q  <= rem_nxt;
      quot_q <= quot_nxt;
      cnt    <= cnt + 6'd1;
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO writer for MULT/MULTU/MTHI/MTLO, plus multi-cycle DIV/DIVU when
// HILO_DIV_EN is defined (otherwise divides are accepted as NOPs).
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input logic         clk,
  input logic         rst,
  hilo_muldiv_if.slave io
);
  state_e      state;
  logic        accept, is_mul, is_div, sgn;
  logic [63:0] prod;
  assign accept = io.start && state == IDLE && !io.flush;
  assign is_mul = io.op == OP_MULT || io.op == OP_MULTU;
  assign is_div = io.op == OP_DIV || io.op == OP_DIVU;
  assign sgn    = io.op == OP_MULT || io.op == OP_DIV;
  assign prod   = {{32{sgn & io.operand_a[31]}}, io.operand_a} *
                  {{32{sgn & io.operand_b[31]}}, io.operand_b};
`ifdef HILO_DIV_EN
  logic                a_neg, b_neg, q_neg, r_neg, div0, last;
  logic [DATA_BUS-1:0] a_hold, quot, rem;
  assign a_neg   = sgn & io.operand_a[31];
  assign b_neg   = sgn & io.operand_b[31];
  assign io.busy = state == DIV_RUN || (accept && is_div);
  div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && is_div),
    .run      (state == DIV_RUN),
    .dividend (cond_neg(io.operand_a, a_neg)),
    .divisor  (cond_neg(io.operand_b, b_neg)),
    .quot_nxt (quot),
    .rem_nxt  (rem),
    .last     (last)
  );
  // sign and divide-by-zero fix-up info captured at accept
  always_ff @(posedge clk) begin
    if (accept && is_div) begin
      q_neg  <= a_neg ^ b_neg;
      r_neg  <= a_neg;
      div0   <= io.operand_b == '0;
      a_hold <= io.operand_a;
    end
  end
`else
  assign io.busy = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      io.hilo_write_en <= 1'b0;
      io.hi_write_data <= '0;
      io.lo_write_data <= '0;
    end else begin
      io.hilo_write_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_mul) {io.hilo_write_en, io.hi_write_data, io.lo_write_data} <= {1'b1, prod};
          else if (io.op == OP_MTHI)
            {io.hilo_write_en, io.hi_write_data, io.lo_write_data} <= {1'b1, io.operand_a, io.lo_input_data};
          else if (io.op == OP_MTLO)
            {io.hilo_write_en, io.hi_write_data, io.lo_write_data} <= {1'b1, io.hi_input_data, io.operand_a};
`ifdef HILO_DIV_EN
          else if (is_div) state <= DIV_RUN;
`endif
        end
`ifdef HILO_DIV_EN
        DIV_RUN: if (io.flush) state <= IDLE;
        else if (last) begin
          state            <= DONE;
          io.hilo_write_en <= 1'b1;
          io.hi_write_data <= div0 ? a_hold : cond_neg(rem, r_neg);
          io.lo_write_data <= div0 ? {DATA_BUS{1'b1}} : cond_neg(quot, q_neg);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard bench for hilo_muldiv; divide checks run when HILO_DIV_EN is defined
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [63:0] sb[$];
  hilo_muldiv_if io();
  hilo_muldiv dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi_in, lo_in);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb_;
    sa  = a;
    sb_ = b;
    case (op)
      3'd1: begin sp = sa; sp = sp * sb_; return sp; end
      3'd2: return {32'b0, a} * {32'b0, b};
      3'd3: if (b == 0) return {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            else return {32'(sa % sb_), 32'(sa / sb_)};
      3'd4: return b == 0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd5: return {a, lo_in};
      3'd6: return {hi_in, a};
      default: return 64'h0;
    endcase
  endfunction
  // every strobe must match the oldest expected result
  always @(negedge clk) begin
    if (io.hilo_write_en) begin
      if (sb.size() == 0) check("spurious_strobe", 64'd1, 64'd0);
      else check("hilo_data", {io.hi_write_data, io.lo_write_data}, sb.pop_front());
    end
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] op, input logic [31:0] a, b, hi_in, lo_in);
    io.start = 1'b1;
    io.op = op;
    io.operand_a = a;
    io.operand_b = b;
    io.hi_input_data = hi_in;
    io.lo_input_data = lo_in;
  endtask
  task automatic mul_op(input logic [2:0] op, input logic [31:0] a, b, hi_in, lo_in, input logic [63:0] exp);
    sb.push_back(exp);
    drive(op, a, b, hi_in, lo_in);
    cycle();
    io.start = 1'b0;
    check("strobe_t1", {63'd0, io.hilo_write_en}, 64'd1);
    check("busy_mul", {63'd0, io.busy}, 64'd0);
  endtask
  task automatic div_op(input logic [2:0] op, input logic [31:0] a, b, input logic [63:0] exp, input bit inject);
    sb.push_back(exp);
    drive(op, a, b, 32'h0, 32'h0);
    #1;
    check("busy_accept", {63'd0, io.busy}, 64'd1);
    cycle();
    for (int i = 1; i <= 32; i++) begin
      check("busy_run", {63'd0, io.busy}, 64'd1);
      io.start = inject && i == 5;
      io.op = 3'd1;
      cycle();
    end
    io.start = 1'b0;
    check("busy_done", {63'd0, io.busy}, 64'd0);
    check("strobe_done", {63'd0, io.hilo_write_en}, 64'd1);
    cycle();
  endtask
  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    io.flush = 1'b0;
    drive(3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    io.start = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_strobe", {63'd0, io.hilo_write_en}, 64'd0);
    check("rst_data", {io.hi_write_data, io.lo_write_data}, 64'd0);
    check("rst_busy", {63'd0, io.busy}, 64'd0);
    mul_op(3'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, {32'hFFFFFFFF, 32'hFFFFFFFA});
    mul_op(3'd2, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, {32'h2, 32'hFFFFFFFA});
    mul_op(3'd5, 32'h1234, 32'h0, 32'h5555, 32'hABCD, {32'h1234, 32'hABCD});
    mul_op(3'd6, 32'h5678, 32'h0, 32'h9999, 32'hABCD, {32'h9999, 32'h5678});
    io.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 2));
      a = $urandom;
      b = $urandom;
      mul_op(op, a, b, 32'h0, 32'h0, model(op, a, b, 32'h0, 32'h0));
    end
    // NOP, reserved and flushed requests must not write
    drive(3'd0, 32'h7, 32'h7, 32'h0, 32'h0);
    cycle();
    io.op = 3'd7;
    cycle();
    io.op = 3'd1;
    io.flush = 1'b1;
    cycle();
    io.flush = 1'b0;
    io.start = 1'b0;
    repeat (2) cycle();
    check("nop_strobe", {63'd0, io.hilo_write_en}, 64'd0);
`ifdef HILO_DIV_EN
    div_op(3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
    div_op(3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    div_op(3'd4, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b0);
    div_op(3'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0);
    div_op(3'd3, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op = 3'($urandom_range(3, 4));
      a = $urandom;
      b = $urandom_range(1, 5000);
      div_op(op, a, b, model(op, a, b, 32'h0, 32'h0), 1'b0);
    end
    mul_op(3'd1, 32'd3, 32'd4, 32'h0, 32'h0, {32'h0, 32'd12});
    io.start = 1'b0;
    drive(3'd3, 32'd50, 32'd3, 32'h0, 32'h0);
    cycle();
    io.start = 1'b0;
    repeat (9) cycle();
    io.flush = 1'b1;
    io.start = 1'b1;
    io.op = 3'd1;
    cycle();
    io.flush = 1'b0;
    io.start = 1'b0;
    check("flush_busy", {63'd0, io.busy}, 64'd0);
    check("flush_strobe", {63'd0, io.hilo_write_en}, 64'd0);
    repeat (30) cycle();
    drive(3'd4, 32'd50, 32'd3, 32'h0, 32'h0);
    cycle();
    io.start = 1'b0;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_busy", {63'd0, io.busy}, 64'd0);
    check("rst_mid_strobe", {63'd0, io.hilo_write_en}, 64'd0);
    repeat (35) cycle();
    div_op(3'd4, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);
`else
    begin
      logic seen;
      drive(3'd3, 32'd9, 32'd3, 32'h0, 32'h0);
      #1;
      seen = io.busy;
      cycle();
      io.start = 1'b0;
      for (int i = 0; i < 34; i++) begin
        seen |= io.busy;
        cycle();
      end
      check("nodiv_busy", {63'd0, seen}, 64'd0);
    end
    mul_op(3'd1, 32'd3, 32'd4, 32'h0, 32'h0, {32'h0, 32'd12});
    io.start = 1'b0;
`endif
    repeat (3) cycle();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle HI/LO writer for the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. Produces the registered `hilo_write_en` / `hi_write_data` / `lo_write_data` triple consumed by the MEM→WB path and by HILOReadProxy forwarding. Raises a stall request while a divide is in flight.

## Interface
- No parameters; widths come from `DATA_BUS` (32 bits) in bus.v.
- Reset: one clock; reset is synchronous and active-high.
- `clk` in, 1: clock; all state changes on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: EX presents a valid HI/LO op this cycle.
- `op` in, 3: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `operand_a` in, `DATA_BUS`: rs value (dividend / multiplicand / MTxx source).
- `operand_b` in, `DATA_BUS`: rt value (divisor / multiplier).
- `hi_input_data` in, `DATA_BUS`: current forwarded HI.
- `lo_input_data` in, `DATA_BUS`: current forwarded LO.
- `flush` in, 1: pipeline flush; aborts an in-flight divide.
- `busy` out, 1: stall request to pipeline control.
- `hilo_write_en` out, 1: one-cycle write strobe.
- `hi_write_data` out, `DATA_BUS`: HI value to write.
- `lo_write_data` out, `DATA_BUS`: LO value to write.

## Operation
- States: IDLE, DIV_RUN, DONE. `rst` forces IDLE, 6-bit iteration counter 0, all outputs 0.
- Accept condition: `start && state==IDLE && !flush`. Ops with `start=0` or `op`=NOP/7 are never accepted.
- MULT/MULTU: 64-bit product of sign- or zero-extended operands; HI = bits 63:32, LO = bits 31:0.
- MTHI: HI = `operand_a`, LO = `lo_input_data`.
- MTLO: LO = `operand_a`, HI = `hi_input_data`.
- DIV/DIVU: restoring radix-2 divide of operand magnitudes, 32 iterations.
  - Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - LO = quotient, HI = remainder.
- Divide by zero (b==0): LO = 32'hFFFFFFFF, HI = `operand_a`. Takes the full 32 iterations; no early exit.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): LO = 32'h80000000, HI = 0.
- Transitions:
  - IDLE → DIV_RUN on accepted DIV/DIVU.
  - DIV_RUN → DONE when counter == 31.
  - DONE → IDLE unconditionally.
- `flush` in DIV_RUN or DONE: return to IDLE next edge, no write strobe; the flushed cycle's `start` is ignored.
- `start` while not IDLE is ignored. Pipeline control holds it under `busy`.

## Timing
- Cycle T = accept cycle.
- MULT/MULTU/MTHI/MTLO:
  - `hilo_write_en` = 1 at T+1 only, data valid at T+1.
  - `busy` stays 0.
  - Back-to-back accepts every cycle are allowed.
- DIV/DIVU:
  - `busy` is combinational-high in T (accept) and registered-high T+1..T+32 (DIV_RUN).
  - DONE at T+33: `hilo_write_en` = 1, `busy` = 0. A new op may be accepted at T+34.
- Outputs are registered; `hi_write_data` / `lo_write_data` hold their last value when the strobe is 0.
- `rst` mid-divide: IDLE next edge, `busy` and `hilo_write_en` 0 next cycle.

## Configuration
- `HILO_DIV_EN` defined: divider instantiated; behaviour as above.
- Undefined:
  - No divider, no DIV_RUN/DONE states.
  - DIV/DIVU are accepted as NOP: no write, `busy` never asserted.
  - MULT/MULTU/MTHI/MTLO unchanged.

## Structure
- bus.v holds `DATA_BUS` and the `op` encodings as `HILO_OP_*` defines, shared with the EX decoder.
- One sub-module: `div_core` — magnitude restoring divider with start/iteration/done, counter, and partial remainder/quotient registers. Sign fix-up and special cases stay in `hilo_muldiv`.

## Test plan
- MULT a=32'hFFFFFFFE (-2), b=3 → T+1: strobe=1, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; MULTU same operands → HI=2, LO=32'hFFFFFFFA.
- DIV a=-7, b=2 → `busy` T..T+32, T+33: strobe=1, LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU 100/7 → LO=14, HI=2.
- DIVU a=5, b=0 → T+33: LO=32'hFFFFFFFF, HI=5; DIV 32'h80000000 / -1 → LO=32'h80000000, HI=0.
- MTHI a=32'h1234 with `lo_input_data`=32'hABCD → T+1: HI=32'h1234, LO=32'hABCD; MTLO back-to-back next cycle → strobe on two consecutive cycles.
- DIV accepted, `flush` at T+10 → IDLE at T+11, `busy`=0, no strobe through T+40; `rst` at T+5 of a second DIV → same outcome.
- Build without `HILO_DIV_EN`: DIV 9/3 → no strobe, `busy` never high; MULT 3×4 → LO=12 at T+1.
